// File: rtl/prog_clk_divider_if.sv
// Control/status bundle for prog_clk_divider: per-channel enables, divisor load
// port, and the divided clock / tick outputs.
interface prog_clk_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 31
);
  localparam int LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              load;
  logic [LCH_W-1:0]  load_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, load, load_ch, div_val,
    input  clk_out, tick
  );

  modport slave (
    input  en, load, load_ch, div_val,
    output clk_out, tick
  );
endinterface

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor reload.
// Optional macro PROG_CLKDIV_SYNC_EN adds a sync input for phase-aligned restart of all channels.
module prog_clk_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 31,
  parameter int DEFAULT_DIV = 20000
) (
  input  logic clk_in,
  input  logic rst,
`ifdef PROG_CLKDIV_SYNC_EN
  input  logic sync,
`endif
  prog_clk_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  tc_q  [NUM_CH];
  logic [CNT_W-1:0]  tc_d  [NUM_CH];
  logic [CNT_W-1:0]  sh_q  [NUM_CH];
  logic [CNT_W-1:0]  sh_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] tc_hit;
  logic [NUM_CH-1:0] load_hit;

  // Out-of-range load_ch values match no channel and are silently dropped.
  always_comb begin
    tc_hit   = '0;
    load_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tc_hit[i]   = bus.en[i] && (cnt_q[i] == tc_q[i]);
      load_hit[i] = bus.load && (32'(bus.load_ch) == i);
    end
  end

  // The shadow is promoted only at terminal count, using the pending flag as it
  // stood before this edge, so a same-cycle load waits for the next terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = tc_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (tc_hit[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = 1'b1;
        if (pend_q[i]) begin
          tc_d[i]   = sh_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (bus.en[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      if (load_hit[i]) begin
        sh_d[i]   = bus.div_val;
        pend_d[i] = 1'b1;
      end

`ifdef PROG_CLKDIV_SYNC_EN
      // Sync restarts the channel with its previously pending divisor; a load in
      // the same cycle lands in the shadow and stays pending.
      if (sync) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        tc_d[i]   = pend_q[i] ? sh_q[i] : tc_q[i];
        pend_d[i] = load_hit[i];
      end
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        tc_q[i]  <= DIV_RST;
        sh_q[i]  <= DIV_RST;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        tc_q[i]  <= tc_d[i];
        sh_q[i]  <= sh_d[i];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed test of prog_clk_divider (NUM_CH=3, DEFAULT_DIV=20000); the sync
// step is built only when PROG_CLKDIV_SYNC_EN is defined.
module tb_prog_clk_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 31;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
`ifdef PROG_CLKDIV_SYNC_EN
  logic sync   = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  prog_clk_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  prog_clk_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(20000)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
`ifdef PROG_CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] c0, c1, c2, t0, t1, t2;

  task automatic sample();
    c0 = {c0[14:0], bus.clk_out[0]};
    c1 = {c1[14:0], bus.clk_out[1]};
    c2 = {c2[14:0], bus.clk_out[2]};
    t0 = {t0[14:0], bus.tick[0]};
    t1 = {t1[14:0], bus.tick[1]};
    t2 = {t2[14:0], bus.tick[2]};
  endtask

  task automatic clr();
    c0 = '0; c1 = '0; c2 = '0; t0 = '0; t1 = '0; t2 = '0;
  endtask

  initial begin
    bus.en      = '1;
    bus.load    = 1'b0;
    bus.load_ch = '0;
    bus.div_val = '0;

    // Held in reset while clocking
    repeat (3) cyc();
    chk("rst_clk_out", 32'(bus.clk_out), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);

    // Release; program shadows (9, 3, 0) during the first default period
    rst = 1'b0;
    bus.load = 1'b1; bus.load_ch = 2'd0; bus.div_val = 31'd9; cyc();
    bus.load_ch = 2'd1; bus.div_val = 31'd3; cyc();
    bus.load_ch = 2'd2; bus.div_val = 31'd0; cyc();
    bus.load = 1'b0;
    repeat (19997) cyc();
    chk("first_rise_pre", 32'(bus.clk_out), 32'h0);
    cyc();
    chk("first_rise_clk", 32'(bus.clk_out), 32'h7);
    chk("first_rise_tick", 32'(bus.tick), 32'h7);

    // Periods, retiming on ch0 (cnt=4 -> div 1), illegal load_ch=3
    clr();
    for (int k = 1; k <= 16; k++) begin
      bus.load = 1'b0;
      if (k == 3) begin
        bus.load = 1'b1; bus.load_ch = 2'd3; bus.div_val = 31'd0;
      end
      if (k == 5) begin
        bus.load = 1'b1; bus.load_ch = 2'd0; bus.div_val = 31'd1;
      end
      cyc();
      sample();
    end
    bus.load = 1'b0;
    chk("retime_ch0_clk", 32'(c0), 32'hFF99);
    chk("retime_ch0_tick", 32'(t0), 32'h0055);
    chk("div4_ch1_clk", 32'(c1), 32'hE1E1);
    chk("div4_ch1_tick", 32'(t1), 32'h1111);
    chk("div0_ch2_clk", 32'(c2), 32'h5555);
    chk("div0_ch2_tick", 32'(t2), 32'hFFFF);

    // Freeze ch1 and ch2 for 5 cycles
    clr();
    for (int k = 17; k <= 28; k++) begin
      bus.en = (k <= 21) ? 3'b001 : 3'b111;
      cyc();
      sample();
    end
    bus.en = '1;
    chk("en_ch0_clk", 32'(c0[11:0]), 32'h999);
    chk("en_ch0_tick", 32'(t0[11:0]), 32'h555);
    chk("en_ch1_clk", 32'(c1[11:0]), 32'hFF0);
    chk("en_ch1_tick", 32'(t1[11:0]), 32'h008);
    chk("en_ch2_clk", 32'(c2[11:0]), 32'hFAA);
    chk("en_ch2_tick", 32'(t2[11:0]), 32'h07F);

`ifdef PROG_CLKDIV_SYNC_EN
    bus.load = 1'b1; bus.load_ch = 2'd0; bus.div_val = 31'd2; cyc();
    bus.load_ch = 2'd1; bus.div_val = 31'd5; cyc();
    bus.load = 1'b0;
    repeat (2) cyc();
    sync = 1'b1; cyc();
    sync = 1'b0;
    chk("sync_clk", 32'(bus.clk_out), 32'h0);
    chk("sync_tick", 32'(bus.tick), 32'h0);
    clr();
    repeat (6) begin
      cyc();
      sample();
    end
    chk("sync_ch0_clk", 32'(c0[5:0]), 32'h0E);
    chk("sync_ch0_tick", 32'(t0[5:0]), 32'h09);
    chk("sync_ch1_clk", 32'(c1[5:0]), 32'h01);
    chk("sync_ch1_tick", 32'(t1[5:0]), 32'h01);
    chk("sync_ch2_clk", 32'(c2[5:0]), 32'h2A);
    chk("sync_ch2_tick", 32'(t2[5:0]), 32'h3F);
`endif

    // Asynchronous reset mid-count, then full default period again
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk", 32'(bus.clk_out), 32'h0);
    chk("async_rst_tick", 32'(bus.tick), 32'h0);
    repeat (2) cyc();
    chk("rst_hold_clk", 32'(bus.clk_out), 32'h0);
    rst = 1'b0;
    repeat (20000) cyc();
    chk("rerise_pre", 32'(bus.clk_out), 32'h0);
    cyc();
    chk("rerise_clk", 32'(bus.clk_out), 32'h7);
    chk("rerise_tick", 32'(bus.tick), 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
